// File: rtl/processor_run_controller_if.sv
// processor_run_controller_if: run request, core observation and run status between a host and the controller
interface processor_run_controller_if #(
  parameter int PC_WIDTH = 32,
  parameter int CNT_WIDTH = 32
);
  logic start;
  logic [PC_WIDTH-1:0] pc_in;
  logic halt_in;
  logic core_reset;
  logic running;
  logic done;
  logic timeout;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [PC_WIDTH-1:0] final_pc;
  modport master (
    output start, pc_in, halt_in,
    input core_reset, running, done, timeout, cycle_count, final_pc
  );
  modport slave (
    input start, pc_in, halt_in,
    output core_reset, running, done, timeout, cycle_count, final_pc
  );
endinterface

// File: rtl/processor_run_controller.sv
// processor_run_controller: holds the core in reset, runs it, and stops on halt, PC self-loop or cycle budget
module processor_run_controller #(
  parameter int PC_WIDTH = 32,
  parameter int CNT_WIDTH = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES = 100,
  parameter int STALL_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  processor_run_controller_if.slave bus
);
  localparam int HW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [CNT_WIDTH-1:0] STALL_CNT = CNT_WIDTH'(STALL_LIMIT);
  typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, DONE, TIMEOUT} state_t;
  state_t state;
  logic [HW-1:0] hold_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] stall_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [PC_WIDTH-1:0] prev_pc;
  logic match;
  logic halt;
  logic restart;
  // decode of this RUN cycle: a zero cycle count marks the first RUN cycle, which can never match
  always_comb begin
    cnt_next = bus.cycle_count + ONE;
    match = bus.cycle_count != '0 && bus.pc_in == prev_pc;
    stall_next = match ? stall_cnt + ONE : '0;
    halt = bus.halt_in || (STALL_LIMIT != 0 && match && stall_next == STALL_CNT);
    restart = bus.start && (state == IDLE || state == DONE || state == TIMEOUT);
  end
  assign bus.core_reset = state == IDLE || state == RESET_HOLD;
  assign bus.running = state == RUN;
  // run sequencer with sticky status, cycle counter and PC captured on leaving RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      stall_cnt <= '0;
      prev_pc <= '0;
      bus.done <= 1'b0;
      bus.timeout <= 1'b0;
      bus.cycle_count <= '0;
      bus.final_pc <= '0;
    end else if (restart) begin
      state <= RESET_HOLD;
      hold_cnt <= HOLD_LOAD;
      stall_cnt <= '0;
      prev_pc <= '0;
      bus.done <= 1'b0;
      bus.timeout <= 1'b0;
      bus.cycle_count <= '0;
      bus.final_pc <= '0;
    end else if (state == RESET_HOLD) begin
      state <= hold_cnt == '0 ? RUN : RESET_HOLD;
      hold_cnt <= hold_cnt - HW'(1);
    end else if (state == RUN) begin
      bus.cycle_count <= cnt_next;
      prev_pc <= bus.pc_in;
      stall_cnt <= stall_next;
      if (halt || cnt_next == MAX_CNT) begin
        state <= halt ? DONE : TIMEOUT;
        bus.done <= halt;
        bus.timeout <= !halt;
        bus.final_pc <= bus.pc_in;
      end
    end
  end
endmodule

// File: tb/tb_processor_run_controller.sv
// tb_processor_run_controller: randomized and directed runs checked against a per-run outcome model
module tb_processor_run_controller;
  localparam int RC = 2;
  localparam int MAXC = 100;
  localparam int SL = 4;
  logic clk = 0;
  logic reset = 1;
  int total = 0;
  int bad = 0;
  logic [31:0] pcs [0:MAXC];
  bit hs [0:MAXC];
  processor_run_controller_if #(.PC_WIDTH(32), .CNT_WIDTH(32)) bus ();
  processor_run_controller #(
    .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // a run ends at the first cycle with halt_in, or whose PC equals the SL preceding RUN-cycle PCs, else at MAXC
  function automatic void model(output int kend, output bit by_halt);
    for (int k = 1; k <= MAXC; k++) begin
      bit st = 0;
      if (SL > 0 && k - SL >= 1) begin
        st = 1;
        for (int j = k - SL; j < k; j++) if (pcs[j] != pcs[k]) st = 0;
      end
      if (hs[k] || st) begin
        kend = k;
        by_halt = 1;
        return;
      end
    end
    kend = MAXC;
    by_halt = 0;
  endfunction
  task automatic fill_inc(input logic [31:0] base);
    for (int k = 0; k <= MAXC; k++) begin
      pcs[k] = base + 32'(4 * k);
      hs[k] = 0;
    end
  endtask
  task automatic fill_rand();
    pcs[0] = $urandom & 32'hffff_fffc;
    hs[0] = 0;
    for (int k = 1; k <= MAXC; k++) begin
      pcs[k] = ($urandom_range(0, 2) == 0) ? pcs[k-1] : pcs[k-1] + 32'd4;
      hs[k] = $urandom_range(0, 79) == 0;
    end
  endtask
  task automatic run(input int abort_at, input bit long_start);
    int kend;
    bit by_halt;
    model(kend, by_halt);
    bus.start = 1;
    tick();
    bus.start = long_start;
    check("hold_core_reset", bus.core_reset, 1);
    check("hold_flags", {bus.done, bus.timeout, bus.running}, 0);
    check("hold_count", bus.cycle_count, 0);
    check("hold_final_pc", bus.final_pc, 0);
    for (int i = 1; i < RC; i++) begin
      tick();
      check("hold_core_reset", bus.core_reset, 1);
      check("hold_running", bus.running, 0);
    end
    bus.start = 0;
    tick();
    check("run_entry", {bus.running, bus.core_reset}, 2'b10);
    for (int k = 1; k <= kend; k++) begin
      bus.pc_in = pcs[k];
      bus.halt_in = hs[k];
      check("run_running", bus.running, 1);
      check("run_count", bus.cycle_count, 64'(k - 1));
      if (k == abort_at) begin
        #2 reset = 0;
        #1;
        check("abort_core_reset", bus.core_reset, 1);
        check("abort_running", bus.running, 0);
        check("abort_count", bus.cycle_count, 0);
        check("abort_flags", {bus.done, bus.timeout}, 0);
        check("abort_final_pc", bus.final_pc, 0);
        bus.halt_in = 0;
        tick();
        reset = 1;
        return;
      end
      tick();
    end
    bus.halt_in = 0;
    check("end_done", bus.done, by_halt);
    check("end_timeout", bus.timeout, !by_halt);
    check("end_count", bus.cycle_count, 64'(kend));
    check("end_final_pc", bus.final_pc, pcs[kend]);
    check("end_outputs", {bus.running, bus.core_reset}, 0);
    bus.pc_in = $urandom;
    tick();
    check("sticky_flags", {bus.done, bus.timeout}, {by_halt, !by_halt});
    check("sticky_count", bus.cycle_count, 64'(kend));
    check("sticky_final_pc", bus.final_pc, pcs[kend]);
  endtask
  initial begin
    bus.start = 0;
    bus.halt_in = 0;
    bus.pc_in = 0;
    #1 reset = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    check("rst_core_reset", bus.core_reset, 1);
    check("rst_running", bus.running, 0);
    check("rst_flags", {bus.done, bus.timeout}, 0);
    check("rst_count", bus.cycle_count, 0);
    check("rst_final_pc", bus.final_pc, 0);
    repeat (3) tick();
    check("idle_stays", {bus.core_reset, bus.running}, 2'b10);
    for (int k = 0; k <= MAXC; k++) begin
      pcs[k] = k <= 6 ? 32'(4 * k) : 32'h18;
      hs[k] = 0;
    end
    run(0, 0);
    check("selfloop_done", {bus.done, bus.timeout}, 2'b10);
    check("selfloop_count", bus.cycle_count, 10);
    check("selfloop_pc", bus.final_pc, 32'h18);
    fill_inc(32'h100);
    run(0, 0);
    check("budget_timeout", {bus.done, bus.timeout}, 2'b01);
    check("budget_count", bus.cycle_count, 100);
    fill_inc(32'h400);
    hs[MAXC] = 1;
    run(0, 1);
    check("tie_done", {bus.done, bus.timeout}, 2'b10);
    check("tie_count", bus.cycle_count, 100);
    fill_inc(32'h800);
    run(37, 0);
    tick();
    check("post_abort_idle", {bus.core_reset, bus.running}, 2'b10);
    check("post_abort_count", bus.cycle_count, 0);
    repeat (12) begin
      fill_rand();
      run(0, 1'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
